// File: rtl/jtag_burst_chain.sv
// JTAG-fed burst writer: a serial command chain loads configuration and data
// words, fills a ping-pong buffer, swaps banks and launches a DMA burst.
module jtag_burst_chain #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned OP_W      = 4,
  parameter int unsigned PP_ADDR_W = 9,
  parameter int unsigned BURST_W   = 8
) (
  input  logic                 JTCK,
  input  logic                 JRST,
  input  logic                 JTDI,
  input  logic                 JSHIFT,
  input  logic                 JUPDATE,
  input  logic                 JCE,
  output logic                 JTDO,
  output logic [PP_ADDR_W-1:0] pp_address,
  output logic                 pp_writeEnable,
  output logic [DATA_W-1:0]    pp_dataIn,
  output logic                 pp_switch,
  input  logic                 switch_ready,
  output logic [31:0]          dma_address,
  output logic [3:0]           dma_byte_enable,
  output logic [BURST_W-1:0]   dma_burst_size,
  output logic                 dma_launch,
  input  logic                 dma_busy,
  output logic [5:0]           status_out
);

  localparam int unsigned CHAIN_W = OP_W + DATA_W;
  localparam int unsigned CNT_W   = BURST_W + 1;

  localparam logic [OP_W-1:0] OP_ADDR     = OP_W'(1);
  localparam logic [OP_W-1:0] OP_BE       = OP_W'(2);
  localparam logic [OP_W-1:0] OP_BURST    = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SEL_ADDR = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SEL_BE   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SEL_BRST = OP_W'(6);
  localparam logic [OP_W-1:0] OP_DATA     = OP_W'(8);
  localparam logic [OP_W-1:0] OP_CLR      = OP_W'(15);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WAIT_SWITCH, S_SWITCH, S_LAUNCH, S_WAIT_DMA
  } state_t;

  typedef enum logic [1:0] {
    SEL_STATUS, SEL_ADDR, SEL_BE, SEL_BURST
  } sel_t;

  logic [CHAIN_W-1:0]   r_chain;
  logic [CHAIN_W-1:0]   r_shadow;
  logic [CHAIN_W-1:0]   r_cap;
  logic                 r_upd_q;
  logic                 r_upd_prev;
  logic [31:0]          r_address;
  logic [3:0]           r_be;
  logic [BURST_W-1:0]   r_burst;
  logic [5:0]           r_status;
  logic [CNT_W-1:0]     r_count;
  sel_t                 r_sel;
  state_t               r_state;
  logic                 r_wd_seen;
  logic                 r_pp_we;
  logic [PP_ADDR_W-1:0] r_pp_addr;
  logic [DATA_W-1:0]    r_pp_data;
  logic                 r_pp_switch;
  logic                 r_dma_launch;

  logic                 w_commit;
  logic [OP_W-1:0]      w_op;
  logic [DATA_W-1:0]    w_payload;
  logic                 w_is_cfg;
  logic                 w_cfg_ok;
  logic                 w_cfg_wr;
  logic [DATA_W-1:0]    w_sel_val;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     w_count_nxt;
  logic [5:0]           w_set;
  logic [5:0]           w_clr;

  assign w_commit  = r_upd_q & ~r_upd_prev;
  assign w_op      = r_cap[OP_W-1:0];
  assign w_payload = r_cap[CHAIN_W-1:OP_W];
  assign w_is_cfg  = (w_op == OP_ADDR) || (w_op == OP_BE) || (w_op == OP_BURST);
  assign w_cfg_ok  = (r_state == S_IDLE) && (r_count == '0);
  assign w_cfg_wr  = w_commit && w_is_cfg && w_cfg_ok;

  // Value presented on the next capture, chosen by the last select opcode.
  always_comb begin
    w_sel_val = DATA_W'(r_status);
    case (r_sel)
      SEL_ADDR:  w_sel_val = DATA_W'(r_address);
      SEL_BE:    w_sel_val = DATA_W'(r_be);
      SEL_BURST: w_sel_val = DATA_W'(r_burst);
      default:   w_sel_val = DATA_W'(r_status);
    endcase
  end

  // Serial chain: shift toward bit 0, or parallel-load the shadow word.
  always_ff @(posedge JTCK or posedge JRST) begin
    if (JRST) begin
      r_chain  <= '0;
      r_shadow <= '0;
    end else begin
      r_shadow <= {w_sel_val, {OP_W{1'b0}}};
      if (JCE && JSHIFT) begin
        r_chain <= {JTDI, r_chain[CHAIN_W-1:1]};
      end else if (JCE) begin
        r_chain <= r_shadow;
      end
    end
  end

  // Update strobe edge detect; the chain is snapshotted alongside it.
  always_ff @(posedge JTCK or posedge JRST) begin
    if (JRST) begin
      r_upd_q    <= 1'b0;
      r_upd_prev <= 1'b0;
      r_cap      <= '0;
    end else begin
      r_upd_q    <= JUPDATE;
      r_upd_prev <= r_upd_q;
      r_cap      <= r_chain;
    end
  end

  // Configuration registers and readback select.
  always_ff @(posedge JTCK or posedge JRST) begin
    if (JRST) begin
      r_address <= '0;
      r_be      <= 4'hF;
      r_burst   <= '0;
      r_sel     <= SEL_STATUS;
    end else begin
      if (w_cfg_wr && (w_op == OP_ADDR))  r_address <= 32'(w_payload);
      if (w_cfg_wr && (w_op == OP_BE))    r_be      <= w_payload[3:0];
      if (w_cfg_wr && (w_op == OP_BURST)) r_burst   <= w_payload[BURST_W-1:0];
      if (w_commit) begin
        case (w_op)
          OP_SEL_ADDR: r_sel <= SEL_ADDR;
          OP_SEL_BE:   r_sel <= SEL_BE;
          OP_SEL_BRST: r_sel <= SEL_BURST;
          OP_ADDR, OP_BE, OP_BURST, OP_DATA, OP_CLR: r_sel <= r_sel;
          default:     r_sel <= SEL_STATUS;
        endcase
      end
    end
  end

  // Next state, word count and status set/clear masks.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_set       = '0;
    w_clr       = '0;

    if (w_commit && w_is_cfg) begin
      if (!w_cfg_ok)               w_set[4] = 1'b1;
      else if (w_op == OP_ADDR)    w_set[0] = 1'b1;
      else if (w_op == OP_BE)      w_set[1] = 1'b1;
      else                         w_set[2] = 1'b1;
    end
    if (w_commit && (w_op == OP_CLR)) w_clr[5:4] = 2'b11;

    case (r_state)
      S_IDLE: begin
        if (w_commit && (w_op == OP_DATA)) begin
          if (&r_status[2:0]) begin
            w_state_nxt = S_WRITE;
            w_set[3]    = 1'b1;
          end else begin
            w_set[4] = 1'b1;
          end
        end
      end
      S_WRITE: begin
        w_count_nxt = r_count + CNT_W'(1);
        w_state_nxt = (r_count == CNT_W'(r_burst)) ? S_WAIT_SWITCH : S_IDLE;
      end
      S_WAIT_SWITCH: begin
        if (switch_ready) w_state_nxt = S_SWITCH;
      end
      S_SWITCH: w_state_nxt = S_LAUNCH;
      S_LAUNCH: begin
        w_state_nxt = S_WAIT_DMA;
        w_count_nxt = '0;
      end
      S_WAIT_DMA: begin
        if (r_wd_seen && !dma_busy) begin
          w_state_nxt = S_IDLE;
          w_set[5]    = 1'b1;
          w_clr[3]    = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_commit && (w_op == OP_DATA) && (r_state != S_IDLE)) w_set[4] = 1'b1;
  end

  // FSM state, word count and status register.
  always_ff @(posedge JTCK or posedge JRST) begin
    if (JRST) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_status  <= '0;
      r_wd_seen <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_status  <= (r_status | w_set) & ~w_clr;
      r_wd_seen <= (r_state == S_WAIT_DMA);
    end
  end

  // Registered buffer and DMA strobes, asserted for the matching state.
  always_ff @(posedge JTCK or posedge JRST) begin
    if (JRST) begin
      r_pp_we      <= 1'b0;
      r_pp_addr    <= '0;
      r_pp_data    <= '0;
      r_pp_switch  <= 1'b0;
      r_dma_launch <= 1'b0;
    end else begin
      r_pp_we      <= (w_state_nxt == S_WRITE);
      r_pp_addr    <= (w_state_nxt == S_WRITE) ? PP_ADDR_W'(r_count) : '0;
      r_pp_data    <= (w_state_nxt == S_WRITE) ? w_payload : '0;
      r_pp_switch  <= (w_state_nxt == S_SWITCH);
      r_dma_launch <= (w_state_nxt == S_LAUNCH);
    end
  end

  assign JTDO            = r_chain[0];
  assign pp_address      = r_pp_addr;
  assign pp_writeEnable  = r_pp_we;
  assign pp_dataIn       = r_pp_data;
  assign pp_switch       = r_pp_switch;
  assign dma_address     = r_address;
  assign dma_byte_enable = r_be;
  assign dma_burst_size  = r_burst;
  assign dma_launch      = r_dma_launch;
  assign status_out      = r_status;

endmodule

// File: tb/tb_jtag_burst_chain.sv
// Randomized bench for jtag_burst_chain against a transaction-level model.
module tb_jtag_burst_chain;

  logic        JTCK = 1'b0;
  logic        JRST = 1'b1;
  logic        JTDI = 1'b0;
  logic        JSHIFT = 1'b0;
  logic        JUPDATE = 1'b0;
  logic        JCE = 1'b0;
  logic        JTDO;
  logic [8:0]  pp_address;
  logic        pp_writeEnable;
  logic [31:0] pp_dataIn;
  logic        pp_switch;
  logic        switch_ready = 1'b0;
  logic [31:0] dma_address;
  logic [3:0]  dma_byte_enable;
  logic [7:0]  dma_burst_size;
  logic        dma_launch;
  logic        dma_busy = 1'b1;
  logic [5:0]  status_out;

  jtag_burst_chain #(.DATA_W(32), .OP_W(4), .PP_ADDR_W(9), .BURST_W(8)) u_dut (
    .JTCK(JTCK), .JRST(JRST), .JTDI(JTDI), .JSHIFT(JSHIFT), .JUPDATE(JUPDATE),
    .JCE(JCE), .JTDO(JTDO), .pp_address(pp_address),
    .pp_writeEnable(pp_writeEnable), .pp_dataIn(pp_dataIn), .pp_switch(pp_switch),
    .switch_ready(switch_ready), .dma_address(dma_address),
    .dma_byte_enable(dma_byte_enable), .dma_burst_size(dma_burst_size),
    .dma_launch(dma_launch), .dma_busy(dma_busy), .status_out(status_out)
  );

  always #5 JTCK = ~JTCK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Observed buffer writes and strobe counts.
  logic [40:0] got_wr[$];
  int          sw_cnt = 0;
  int          la_cnt = 0;
  logic [31:0] la_addr = '0;
  logic [3:0]  la_be = '0;
  logic [7:0]  la_burst = '0;

  always @(negedge JTCK) begin
    if (!JRST) begin
      if (pp_writeEnable) got_wr.push_back({pp_address, pp_dataIn});
      if (pp_switch) sw_cnt <= sw_cnt + 1;
      if (dma_launch) begin
        la_cnt   <= la_cnt + 1;
        la_addr  <= dma_address;
        la_be    <= dma_byte_enable;
        la_burst <= dma_burst_size;
      end
    end
  end

  // Reference model: config, status and burst progress at transaction level.
  logic [31:0] m_addr;
  logic [3:0]  m_be;
  logic [7:0]  m_burst;
  logic [5:0]  m_st;
  int          m_phase;   // 0 no burst, 1 collecting words, 2 burst closed
  int          m_count;
  int          m_sel;     // 0 status, 1 address, 2 byte enable, 3 burst
  logic [40:0] exp_wr[$];

  task automatic model_reset();
    m_addr = '0; m_be = 4'hF; m_burst = '0; m_st = '0;
    m_phase = 0; m_count = 0; m_sel = 0;
    exp_wr.delete();
    got_wr.delete();
  endtask

  function automatic logic [31:0] model_sel_val();
    case (m_sel)
      1:       return m_addr;
      2:       return {28'h0, m_be};
      3:       return {24'h0, m_burst};
      default: return {26'h0, m_st};
    endcase
  endfunction

  task automatic shift_word(input logic [35:0] din, output logic [35:0] dout);
    for (int i = 0; i < 36; i++) begin
      @(negedge JTCK);
      dout[i] = JTDO;
      JCE = 1'b1; JSHIFT = 1'b1; JTDI = din[i];
    end
    @(negedge JTCK);
    JCE = 1'b0; JSHIFT = 1'b0; JTDI = 1'b0;
  endtask

  task automatic read_chain(output logic [35:0] d);
    @(negedge JTCK);
    JCE = 1'b1; JSHIFT = 1'b0;
    shift_word(36'h0, d);
  endtask

  task automatic send_op(input logic [3:0] op, input logic [31:0] pl);
    logic [35:0] dummy;
    shift_word({pl, op}, dummy);
    @(negedge JTCK) JUPDATE = 1'b1;
    @(negedge JTCK) JUPDATE = 1'b0;
    repeat (3) @(negedge JTCK);
    case (op)
      4'd1, 4'd2, 4'd3: begin
        if (m_phase != 0) m_st[4] = 1'b1;
        else if (op == 4'd1) begin m_addr = pl; m_st[0] = 1'b1; end
        else if (op == 4'd2) begin m_be = pl[3:0]; m_st[1] = 1'b1; end
        else begin m_burst = pl[7:0]; m_st[2] = 1'b1; end
      end
      4'd4: m_sel = 1;
      4'd5: m_sel = 2;
      4'd6: m_sel = 3;
      4'd8: begin
        if (m_phase == 2 || m_st[2:0] != 3'b111) m_st[4] = 1'b1;
        else begin
          exp_wr.push_back({9'(m_count), pl});
          m_st[3] = 1'b1;
          m_count++;
          m_phase = (m_count == int'(m_burst) + 1) ? 2 : 1;
        end
      end
      4'd15: m_st[5:4] = 2'b00;
      default: m_sel = 0;
    endcase
  endtask

  task automatic wait_done();
    int k = 0;
    while (!status_out[5] && k < 50) begin
      @(negedge JTCK);
      k++;
    end
    m_st[5] = 1'b1; m_st[3] = 1'b0; m_phase = 0; m_count = 0;
    chk("done_status", 64'(status_out), 64'(m_st));
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, 64'(got_wr.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
      chk({tag, "_wr"}, 64'(got_wr[i]), 64'(exp_wr[i]));
  endtask

  task automatic run_burst(input int it);
    logic [31:0] r, a, pbe, pbr;
    logic [35:0] d;
    int sw0, la0;
    a = $urandom;
    r = $urandom; pbe = {r[31:4], 4'(r[3:0])};
    r = $urandom; pbr = {r[31:8], 8'($urandom_range(0, 4))};
    if (it == 0) begin a = 32'h1000_0040; pbe = 32'hF; pbr = 32'd3; end
    if (it == 1) pbr[7:0] = 8'd0;
    send_op(4'd1, a);
    send_op(4'd2, pbe);
    send_op(4'd3, pbr);
    chk("cfg_status", 64'(status_out), 64'(m_st));
    send_op(4'd4, $urandom); read_chain(d);
    chk("rd_addr", 64'(d), 64'({model_sel_val(), 4'h0}));
    send_op(4'd5, $urandom); read_chain(d);
    chk("rd_be", 64'(d), 64'({model_sel_val(), 4'h0}));
    send_op(4'd6, $urandom); read_chain(d);
    chk("rd_burst", 64'(d), 64'({model_sel_val(), 4'h0}));
    switch_ready = 1'b0; dma_busy = 1'b1;
    got_wr.delete(); exp_wr.delete();
    sw0 = sw_cnt; la0 = la_cnt;
    for (int w = 0; w <= int'(m_burst); w++) send_op(4'd8, $urandom);
    send_op(4'd8, $urandom);
    check_writes("burst");
    chk("burst_status", 64'(status_out), 64'(m_st));
    repeat (20) @(negedge JTCK);
    chk("hold_no_switch", 64'(sw_cnt - sw0), 64'd0);
    send_op(4'd1, $urandom);
    chk("late_cfg_addr", 64'(dma_address), 64'(m_addr));
    @(negedge JTCK) switch_ready = 1'b1;
    @(negedge JTCK) chk("switch_lat", 64'(pp_switch), 64'd1);
    switch_ready = 1'b0;
    repeat (3) @(negedge JTCK);
    chk("switch_cnt", 64'(sw_cnt - sw0), 64'd1);
    chk("launch_cnt", 64'(la_cnt - la0), 64'd1);
    chk("launch_addr", 64'(la_addr), 64'(m_addr));
    chk("launch_be", 64'(la_be), 64'(m_be));
    chk("launch_burst", 64'(la_burst), 64'(m_burst));
    send_op(4'd1, $urandom);
    chk("dma_cfg_addr", 64'(dma_address), 64'(m_addr));
    chk("dma_err_status", 64'(status_out), 64'(m_st));
    dma_busy = 1'b0;
    wait_done();
    send_op(4'd15, 32'h0);
    chk("clr_status", 64'(status_out), 64'(m_st));
    dma_busy = 1'b1;
  endtask

  initial begin
    logic [35:0] d;
    int sw0, la0;
    model_reset();
    repeat (3) @(negedge JTCK);
    chk("rst_status", 64'(status_out), 64'(m_st));
    chk("rst_cfg", 64'({dma_address, dma_byte_enable, dma_burst_size}),
        64'({m_addr, m_be, m_burst}));
    chk("rst_strobes", 64'({pp_writeEnable, pp_switch, dma_launch, pp_address, JTDO}), 64'd0);
    chk("rst_data", 64'(pp_dataIn), 64'd0);
    @(negedge JTCK) JRST = 1'b0;

    send_op(4'd8, $urandom);
    chk("early_nwr", 64'(got_wr.size()), 64'd0);
    chk("early_status", 64'(status_out), 64'(m_st));
    send_op(4'd15, 32'h0);
    chk("early_clr", 64'(status_out), 64'(m_st));
    send_op(4'd9, $urandom); read_chain(d);
    chk("rd_status", 64'(d), 64'({model_sel_val(), 4'h0}));

    for (int it = 0; it < 4; it++) run_burst(it);

    // Reset in the middle of a 4-word burst.
    send_op(4'd3, 32'd3);
    switch_ready = 1'b1; dma_busy = 1'b0;
    got_wr.delete(); exp_wr.delete();
    send_op(4'd8, $urandom);
    send_op(4'd8, $urandom);
    send_op(4'd1, $urandom);
    chk("mid_cfg_addr", 64'(dma_address), 64'(m_addr));
    chk("mid_status", 64'(status_out), 64'(m_st));
    @(negedge JTCK) JRST = 1'b1;
    #1 chk("async_rst_status", 64'(status_out), 64'd0);
    @(negedge JTCK) JRST = 1'b0;
    model_reset();
    sw0 = sw_cnt; la0 = la_cnt;
    repeat (10) @(negedge JTCK);
    chk("rst_no_switch", 64'(sw_cnt - sw0), 64'd0);
    chk("rst_no_launch", 64'(la_cnt - la0), 64'd0);
    send_op(4'd1, $urandom);
    send_op(4'd2, $urandom);
    send_op(4'd3, 32'd1);
    send_op(4'd8, $urandom);
    send_op(4'd8, $urandom);
    check_writes("restart");
    repeat (4) @(negedge JTCK);
    chk("restart_launch", 64'(la_cnt - la0), 64'd1);
    chk("restart_launch_addr", 64'(la_addr), 64'(m_addr));
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/jtag_burst_chain.md
JTAG_BURST_CHAIN -- requirements
Module: jtag_burst_chain

Interface
REQ-001 SHALL provide parameter DATA_W, default 32: payload width of one shifted word and one buffer word.
REQ-002 SHALL provide parameter OP_W, default 4: opcode field width, bits [OP_W-1:0] of the chain.
REQ-003 SHALL provide parameter PP_ADDR_W, default 9: ping-pong buffer address width.
REQ-004 SHALL provide parameter BURST_W, default 8: burst length register width; BURST_W <= PP_ADDR_W.
REQ-005 SHALL have ports:
- JTCK  in  1  sole clock, all logic on rising edge.
- JRST  in  1  asynchronous, active-high reset.
- JTDI  in  1  serial data in.
- JSHIFT  in  1  shift enable.
- JUPDATE  in  1  update strobe.
- JCE  in  1  chain select.
- JTDO  out  1  serial data out = chain bit 0.
- pp_address  out  PP_ADDR_W  buffer word address.
- pp_writeEnable  out  1  buffer write strobe.
- pp_dataIn  out  DATA_W  buffer write data.
- pp_switch  out  1  one-cycle bank swap pulse.
- switch_ready  in  1  buffer may swap.
- dma_address  out  32  burst start address.
- dma_byte_enable  out  4  byte lanes.
- dma_burst_size  out  BURST_W  words minus one.
- dma_launch  out  1  one-cycle start pulse.
- dma_busy  in  1  DMA transfer in progress.
- status_out  out  6  status register.

Function
REQ-006 SHALL hold an OP_W+DATA_W chain; JCE&JSHIFT: shift right, JTDI into MSB; JCE&!JSHIFT: load shadow word; else hold.
REQ-007 SHALL register JUPDATE and commit only on its rising edge (update_q=1, prev=0), one JTCK after the edge, using the chain contents captured at the edge.
REQ-008 Opcodes: 1 address<=payload[31:0]; 2 byte_enable<=payload[3:0]; 3 burst<=payload[BURST_W-1:0]; 4/5/6 select address/byte_enable/burst for next capture; 8 data word; F clear status[4] and status[5]; any other selects status.
REQ-009 Shadow SHALL be {selected value zero-extended to DATA_W, OP_W'b0}; the default selection is status.
REQ-010 Opcodes 1/2/3 SHALL set status bits 0/1/2; while state != IDLE or word count != 0 they SHALL be ignored and set status[4] (error).
REQ-011 FSM states: IDLE, WRITE, WAIT_SWITCH, SWITCH, LAUNCH, WAIT_DMA.
REQ-012 IDLE: opcode 8 with status[2:0]=111 -> WRITE; opcode 8 otherwise -> set status[4], word dropped, stay IDLE.
REQ-013 WRITE (one cycle): pp_writeEnable=1, pp_dataIn=payload, pp_address=word count; count+1; if count==burst -> WAIT_SWITCH, else -> IDLE.
REQ-014 WAIT_SWITCH: stay until switch_ready=1 -> SWITCH; SWITCH: pp_switch=1 for one cycle -> LAUNCH.
REQ-015 LAUNCH: dma_launch=1 for one cycle, dma_address/byte_enable/burst_size valid -> WAIT_DMA; count<=0.
REQ-016 WAIT_DMA: leave to IDLE on the first cycle with dma_busy=0 after at least one cycle in WAIT_DMA, setting status[5] (done); status[3] cleared.
REQ-017 Opcode 8 received in any state other than IDLE SHALL set status[4] and be dropped; the FSM is unaffected.
REQ-018 status[3] (busy) SHALL be 1 from the first accepted data word until return to IDLE from WAIT_DMA.
REQ-019 burst=N SHALL transfer exactly N+1 words; burst=0 is a single-word burst.
REQ-020 Word count SHALL be BURST_W+1 bits wide; it never wraps, because the burst terminates at count==burst.
REQ-021 dma_* outputs SHALL drive the configuration registers continuously; dma_launch alone qualifies them.
REQ-022 When commit and an FSM event coincide in one cycle, both take effect; status bit sets and clears merge by OR, and clear (opcode F) wins over a same-cycle error set.

Reset
REQ-023 JRST=1 SHALL immediately set: chain, shadow, address, count=0; byte_enable=4'hF; burst=0; status=0; state=IDLE; all pulse outputs and pp_* outputs 0.
REQ-024 Reset asserted mid-burst SHALL abandon the burst without issuing pp_switch or dma_launch.

Verification
REQ-025 Shift op1 addr 0x1000_0040, op2 BE 0xF, op3 burst 3, then 4 op8 words -> 4 pp writes at addresses 0..3, then pp_switch once switch_ready=1, then dma_launch with dma_address 0x1000_0040 and dma_burst_size 3.
REQ-026 op8 before any config -> no pp write, status_out=6'b010000; then opF -> status_out=0.
REQ-027 Hold switch_ready=0 for 20 cycles after the last word -> stays in WAIT_SWITCH, no pp_switch; release -> pp_switch 1 cycle later.
REQ-028 op1 during WAIT_DMA -> address unchanged, status[4]=1; dma_busy falls -> status[5]=1, status[3]=0.
REQ-029 op4 then capture/shift 36 bits -> JTDO emits {address, 4'b0} LSB first.
REQ-030 JRST pulse after word 2 of a 4-word burst -> status 0, no dma_launch; a new burst restarts at pp_address 0.
